rfp_frame_buffer: RTL and testbench
===================================

Name: rfp_frame_buffer

Overview:
Parametrised successor to the fixed-size RFP RAM. It captures multi-channel RF-power samples into a frame-organised circular buffer and exposes control, status, pointer registers and the buffer over a WISHBONE slave. Depth, channel count and sample width are parameters. It adds wrap/stop-on-full modes, overflow detection and PPS pointer tagging. It sits behind the RFP address window; the sample producer is the PicoBlaze port path or a future hardware sampler.

Parameters:
NCHAN, 12, channels per frame (1..32); CHAN_BITS = clog2(NCHAN)
DATA_WIDTH, 16, sample width (1..32), zero-extended on readout
FRAME_BITS, 10, log2 of the number of frames; RAM depth = 2^(FRAME_BITS+CHAN_BITS) words
WB_ADR_WIDTH, 19, WISHBONE byte-address width; must be at least FRAME_BITS+CHAN_BITS+3

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
wbc_cyc_i  in  1  WB cycle
wbc_stb_i  in  1  WB strobe
wbc_we_i  in  1  WB write enable
wbc_adr_i  in  WB_ADR_WIDTH  WB byte address; [1:0] ignored
wbc_dat_i  in  32  WB write data
wbc_dat_o  out  32  WB read data
wbc_ack_o  out  1  WB acknowledge
wbc_err_o  out  1  tied 0
wbc_rty_o  out  1  tied 0
smp_valid_i  in  1  sample strobe, one sample per cycle max
smp_chan_i  in  CHAN_BITS  channel index of sample
smp_dat_i  in  DATA_WIDTH  sample value
pps_i  in  1  PPS, synchronous to clk_i, level

Behaviour:
- One clock (clk_i); synchronous active-high reset (rst_i). Reset: CTRL=0, state IDLE, wr_ptr=0, overflow=0, pps_ptr=0, pps_seen=0, wbc_ack_o=0, wbc_dat_o=0.
- Address decode: adr[FRAME_BITS+CHAN_BITS+2]=1 selects RAM, word index adr[FRAME_BITS+CHAN_BITS+1:2] = {frame, chan}. Otherwise registers by adr[3:2]; upper address bits are ignored (shadowed).
- Registers:
  - 0x0 CTRL (RW): bit0 enable; bit1 wrap mode (1 = overwrite, 0 = stop when full); bit2 clear (write-1 pulse, reads 0).
  - 0x4 STATUS (RO): bit0 full; bit1 overflow (sticky); bits[3:2] state; bits[31:16] frames written since clear, saturating at 0xFFFF.
  - 0x8 WR_PTR (RO): current frame pointer, zero-extended.
  - 0xC PPS_PTR (RO): bit31 pps_seen; [FRAME_BITS-1:0] frame pointer captured on the pps_i rising edge.
- WB handshake: ack <= cyc & stb & !ack. One-cycle ack, latency 1, back-to-back accesses ack every other cycle. Read data is registered in the same cycle as ack. RAM writes from WB are ignored but still acked. The RAM read port is synchronous; address is presented while stb is high, data is valid at ack.
- State machine:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> IDLE, pointer is kept.
  - RUN: mode 0 and a frame completes with wr_ptr = 2^FRAME_BITS-1 -> FULL, wr_ptr wraps to 0.
  - FULL: enable=0 -> IDLE; clear -> IDLE.
- Capture: in RUN, smp_valid_i writes smp_dat_i to RAM[{wr_ptr, smp_chan_i}]. A sample with smp_chan_i = NCHAN-1 completes the frame: wr_ptr+1 mod 2^FRAME_BITS and frame count+1. Channel indices >= NCHAN are discarded and set overflow.
- Sample in IDLE: dropped silently. Sample in FULL: dropped and sets overflow.
- Wrap mode: wr_ptr wraps and the full bit sets on the first wrap, but the state stays RUN.
- Clear: wr_ptr=0, count=0, full=0, overflow=0, pps_seen=0, state IDLE. Enable and mode are kept but take effect next cycle. Clear has priority over a same-cycle sample; that sample is dropped.
- A CTRL write in the same cycle as a sample: the sample uses the pre-write state.
- PPS: rising edge detected with a 1-cycle register. If a frame completes in the same cycle, the post-increment pointer is captured.
- Reset mid-capture: the pointer is lost; RAM contents are undefined-but-stable (not cleared).

Optional Feature:
RFP_PPS_TAG_EN: when defined, PPS edge detection and the PPS_PTR register are built. When undefined, pps_i is unused, PPS_PTR reads 0 and the related logic is removed.

Decomposition:
- Package rfp_pkg: register offsets (REG_CTRL, REG_STATUS, REG_WRPTR, REG_PPSPTR), CTRL/STATUS bit indices, state encodings (ST_IDLE=0, ST_RUN=1, ST_FULL=2).
- Sub-module rfp_frame_ram: simple dual-port BRAM (write port A, synchronous read port B), parametrised width/depth, inferable.

Test Plan:
- Reset, then read all four registers -> CTRL=0, STATUS=0, WR_PTR=0, PPS_PTR=0; each ack is exactly 1 cycle wide.
- NCHAN=12, FRAME_BITS=2, CTRL=0x1, push 4 frames (sample value = frame*16+chan) -> state FULL, full=1, WR_PTR=0. RAM word {2,5} reads 0x25. A 5th sample sets overflow.
- Same setup with CTRL=0x3, push 5 frames -> state RUN, full=1, WR_PTR=1, count=5; frame 0 is overwritten with frame-4 data.
- Sample with chan=13 in RUN -> overflow=1, no RAM write, WR_PTR unchanged.
- Write CTRL=0x5 in the same cycle as a chan=NCHAN-1 sample -> sample dropped, WR_PTR=0, state IDLE.
- RFP_PPS_TAG_EN defined: after 3 frames raise pps_i for 10 cycles -> PPS_PTR=0x80000003, captured once. With the macro undefined, PPS_PTR reads 0.

Source files
------------

// File: rtl/rfp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rfp_pkg                                                              |
// | Register map, bit indices and state encodings for rfp_frame_buffer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rfp_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_WRPTR  = 2'd2;
  localparam logic [1:0] REG_PPSPTR = 2'd3;

  localparam int c_ctrl_en       = 0;
  localparam int c_ctrl_wrap     = 1;
  localparam int c_ctrl_clr      = 2;
  localparam int c_stat_full     = 0;
  localparam int c_stat_ovf      = 1;
  localparam int c_pps_seen_bit  = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rfp_frame_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rfp_frame_ram                                                        |
// | Simple dual-port RAM: write port A, synchronous read port B.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rfp_frame_ram #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk_i,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]     i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [WIDTH-1:0]     o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk_i) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/rfp_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rfp_frame_buffer                                                     |
// | Frame-organised circular RF-power capture buffer behind a WISHBONE   |
// | slave. Optional PPS pointer tagging built when RFP_PPS_TAG_EN is set.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rfp_frame_buffer
  import rfp_pkg::*;
#(
  parameter int NCHAN        = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAME_BITS   = 10,
  parameter int WB_ADR_WIDTH = 19,
  localparam int CHAN_BITS   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wbc_cyc_i,
  input  logic                    wbc_stb_i,
  input  logic                    wbc_we_i,
  input  logic [WB_ADR_WIDTH-1:0] wbc_adr_i,
  input  logic [31:0]             wbc_dat_i,
  output logic [31:0]             wbc_dat_o,
  output logic                    wbc_ack_o,
  output logic                    wbc_err_o,
  output logic                    wbc_rty_o,
  input  logic                    smp_valid_i,
  input  logic [CHAN_BITS-1:0]    smp_chan_i,
  input  logic [DATA_WIDTH-1:0]   smp_dat_i,
  input  logic                    pps_i
);

  localparam int c_ram_aw  = FRAME_BITS + CHAN_BITS;
  localparam int c_ram_sel = c_ram_aw + 2;
  localparam logic [CHAN_BITS-1:0] c_last_chan = CHAN_BITS'(NCHAN - 1);

  logic                  r_ack;
  logic                  r_rd_ram;
  logic [31:0]           r_rdata;
  logic                  r_en;
  logic                  r_wrap;
  state_t                r_state;
  logic [FRAME_BITS-1:0] r_wr_ptr;
  logic [15:0]           r_count;
  logic                  r_full;
  logic                  r_ovf;

  logic                  w_req;
  logic                  w_ram_sel;
  logic [1:0]            w_reg_sel;
  logic                  w_ctrl_wr;
  logic                  w_clear;
  logic                  w_in_run;
  logic                  w_smp_ok;
  logic                  w_bad_chan;
  logic                  w_frame_done;
  logic                  w_ptr_last;
  logic [FRAME_BITS-1:0] w_wr_ptr_next;
  logic [31:0]           w_reg_rdata;
  logic [31:0]           w_pps_reg;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [31:0]           w_ram_word;

  assign wbc_err_o = 1'b0;
  assign wbc_rty_o = 1'b0;
  assign wbc_ack_o = r_ack;

  assign w_req     = wbc_cyc_i & wbc_stb_i & ~r_ack;
  assign w_ram_sel = wbc_adr_i[c_ram_sel];
  assign w_reg_sel = wbc_adr_i[3:2];
  assign w_ctrl_wr = w_req & wbc_we_i & ~w_ram_sel & (w_reg_sel == REG_CTRL);
  assign w_clear   = w_ctrl_wr & wbc_dat_i[c_ctrl_clr];

  // Capture decisions use the pre-write state; clear wins over a same-cycle sample.
  assign w_in_run      = smp_valid_i & (r_state == ST_RUN) & ~w_clear;
  assign w_smp_ok      = w_in_run & (smp_chan_i <= c_last_chan);
  assign w_bad_chan    = w_in_run & (smp_chan_i > c_last_chan);
  assign w_frame_done  = w_smp_ok & (smp_chan_i == c_last_chan);
  assign w_ptr_last    = &r_wr_ptr;
  assign w_wr_ptr_next = w_frame_done ? r_wr_ptr + FRAME_BITS'(1) : r_wr_ptr;

  rfp_frame_ram #(
    .WIDTH     (DATA_WIDTH),
    .ADDR_BITS (c_ram_aw)
  ) u_ram (
    .clk_i     (clk_i),
    .i_wr_en   (w_smp_ok),
    .i_wr_addr ({r_wr_ptr, smp_chan_i}),
    .i_wr_data (smp_dat_i),
    .i_rd_en   (w_req & w_ram_sel),
    .i_rd_addr (wbc_adr_i[c_ram_aw+1:2]),
    .o_rd_data (w_ram_q)
  );

  generate
    if (DATA_WIDTH < 32) begin : g_zext
      assign w_ram_word = {{(32-DATA_WIDTH){1'b0}}, w_ram_q};
    end else begin : g_full
      assign w_ram_word = w_ram_q;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en   <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en   <= wbc_dat_i[c_ctrl_en];
      r_wrap <= wbc_dat_i[c_ctrl_wrap];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_clear) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      if (w_frame_done) begin
        r_count <= sat_inc16(r_count);
        if (w_ptr_last) r_full <= 1'b1;
      end
      if (w_bad_chan || (smp_valid_i && r_state == ST_FULL)) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: if (r_en) r_state <= ST_RUN;
        ST_RUN: begin
          if (!r_en)
            r_state <= ST_IDLE;
          else if (w_frame_done && w_ptr_last && !r_wrap)
            r_state <= ST_FULL;
        end
        ST_FULL: if (!r_en) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RFP_PPS_TAG_EN
  logic                  r_pps_d;
  logic                  r_pps_seen;
  logic [FRAME_BITS-1:0] r_pps_ptr;

  // The post-increment pointer is tagged when a frame completes on the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pps_d    <= 1'b0;
      r_pps_seen <= 1'b0;
      r_pps_ptr  <= '0;
    end else begin
      r_pps_d <= pps_i;
      if (w_clear) begin
        r_pps_seen <= 1'b0;
      end else if (pps_i && !r_pps_d) begin
        r_pps_seen <= 1'b1;
        r_pps_ptr  <= w_wr_ptr_next;
      end
    end
  end

  always_comb begin
    w_pps_reg                 = 32'(r_pps_ptr);
    w_pps_reg[c_pps_seen_bit] = r_pps_seen;
  end

  logic w_unused;
  assign w_unused = ^{wbc_adr_i, wbc_dat_i};
`else
  assign w_pps_reg = '0;

  logic w_unused;
  assign w_unused = ^{wbc_adr_i, wbc_dat_i, pps_i};
`endif

  always_comb begin
    w_reg_rdata = '0;
    case (w_reg_sel)
      REG_CTRL: begin
        w_reg_rdata[c_ctrl_en]   = r_en;
        w_reg_rdata[c_ctrl_wrap] = r_wrap;
      end
      REG_STATUS: w_reg_rdata = {r_count, 12'd0, r_state, r_ovf, r_full};
      REG_WRPTR:  w_reg_rdata = 32'(r_wr_ptr);
      default:    w_reg_rdata = w_pps_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack    <= 1'b0;
      r_rd_ram <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        r_rd_ram <= w_ram_sel;
        r_rdata  <= w_reg_rdata;
      end
    end
  end

  // RAM data is already registered inside the RAM, so only the source is muxed.
  assign wbc_dat_o = r_rd_ram ? w_ram_word : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rfp_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rfp_frame_buffer                                                  |
// | Randomised scoreboard bench for rfp_frame_buffer (NCHAN=12, 4 frames)|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rfp_frame_buffer;

  localparam int NCHAN = 12;
  localparam int NF    = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wbc_cyc_i, wbc_stb_i, wbc_we_i;
  logic [18:0] wbc_adr_i;
  logic [31:0] wbc_dat_i, wbc_dat_o;
  logic        wbc_ack_o, wbc_err_o, wbc_rty_o;
  logic        smp_valid_i;
  logic [3:0]  smp_chan_i;
  logic [15:0] smp_dat_i;
  logic        pps_i;

  rfp_frame_buffer #(
    .NCHAN(NCHAN), .DATA_WIDTH(16), .FRAME_BITS(2), .WB_ADR_WIDTH(19)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wbc_cyc_i(wbc_cyc_i), .wbc_stb_i(wbc_stb_i), .wbc_we_i(wbc_we_i),
    .wbc_adr_i(wbc_adr_i), .wbc_dat_i(wbc_dat_i), .wbc_dat_o(wbc_dat_o),
    .wbc_ack_o(wbc_ack_o), .wbc_err_o(wbc_err_o), .wbc_rty_o(wbc_rty_o),
    .smp_valid_i(smp_valid_i), .smp_chan_i(smp_chan_i), .smp_dat_i(smp_dat_i),
    .pps_i(pps_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: buffer contents keyed by frame*16+chan, counters as plain ints.
  int m_state, m_en, m_wrap, m_ptr, m_count, m_full, m_ovf;
  int m_pps_seen, m_pps_ptr, m_pps_d, m_ack;
  logic [31:0] m_mem [int];

  task automatic model_reset();
    m_state = 0; m_en = 0; m_wrap = 0; m_ptr = 0; m_count = 0; m_full = 0;
    m_ovf = 0; m_pps_seen = 0; m_pps_ptr = 0; m_pps_d = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit valid, input int chan, input logic [15:0] dat,
                            input bit ctrl_wr, input logic [31:0] wdat, input bit pps);
    bit rise;
    bit wrapped;
    rise    = pps && (m_pps_d == 0);
    wrapped = 0;
    m_pps_d = pps;
    if (ctrl_wr && wdat[2]) begin
      m_state = 0; m_ptr = 0; m_count = 0; m_full = 0; m_ovf = 0; m_pps_seen = 0;
    end else begin
      if (valid && m_state == 1) begin
        if (chan >= NCHAN) m_ovf = 1;
        else begin
          m_mem[m_ptr*16 + chan] = 32'(dat);
          if (chan == NCHAN-1) begin
            if (m_ptr == NF-1) begin wrapped = 1; m_full = 1; end
            m_ptr = (m_ptr + 1) % NF;
            if (m_count < 65535) m_count++;
          end
        end
      end else if (valid && m_state == 2) m_ovf = 1;
      case (m_state)
        0: if (m_en != 0) m_state = 1;
        1: if (m_en == 0) m_state = 0; else if (wrapped && m_wrap == 0) m_state = 2;
        default: if (m_en == 0) m_state = 0;
      endcase
`ifdef RFP_PPS_TAG_EN
      if (rise) begin m_pps_seen = 1; m_pps_ptr = m_ptr; end
`else
      if (rise) m_pps_d = 1;
`endif
    end
    if (ctrl_wr) begin m_en = int'(wdat[0]); m_wrap = int'(wdat[1]); end
  endtask

  function automatic logic [31:0] model_read(input logic [18:0] a);
    int idx;
    if (a[8]) begin
      idx = int'(a[7:2]);
      return m_mem.exists(idx) ? m_mem[idx] : 32'd0;
    end
    case (a[3:2])
      2'd0: return 32'(m_en + 2*m_wrap);
      2'd1: return 32'(m_count*65536 + m_state*4 + m_ovf*2 + m_full);
      2'd2: return 32'(m_ptr);
`ifdef RFP_PPS_TAG_EN
      default: return (m_pps_seen != 0) ? (32'h8000_0000 | 32'(m_pps_ptr)) : 32'(m_pps_ptr);
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic bit model_known(input logic [18:0] a);
    if (a[8]) return m_mem.exists(int'(a[7:2]));
    return 1'b1;
  endfunction

  function automatic string nm(input logic [18:0] a);
    if (a[8]) return $sformatf("ram[%0d,%0d]", a[7:6], a[5:2]);
    case (a[3:2])
      2'd0: return "ctrl";
      2'd1: return "status";
      2'd2: return "wr_ptr";
      default: return "pps_ptr";
    endcase
  endfunction

  function automatic logic [18:0] reg_adr(input int off);
    return {10'($urandom), 1'b0, 4'($urandom), 2'(off), 2'($urandom)};
  endfunction

  function automatic logic [18:0] ram_adr(input int f, input int c);
    return {10'($urandom), 1'b1, 2'(f), 4'(c), 2'($urandom)};
  endfunction

  // One clock: expected read data is captured from the model before it advances.
  task automatic step();
    bit req;
    bit ctrl_wr;
    exp_t e;
    req     = wbc_cyc_i && wbc_stb_i && (m_ack == 0);
    ctrl_wr = req && wbc_we_i && !wbc_adr_i[8] && (wbc_adr_i[3:2] == 2'd0);
    if (req) begin
      e.name = nm(wbc_adr_i);
      e.chk  = !wbc_we_i && model_known(wbc_adr_i);
      e.exp  = model_read(wbc_adr_i);
      q.push_back(e);
    end
    model_step(smp_valid_i, int'(smp_chan_i), smp_dat_i, ctrl_wr, wbc_dat_i, pps_i);
    m_ack = int'(req);
    @(posedge clk);
    #1;
  endtask

  task automatic wb_access(input logic [18:0] a, input bit w, input logic [31:0] d);
    wbc_cyc_i = 1; wbc_stb_i = 1; wbc_we_i = w; wbc_adr_i = a; wbc_dat_i = d;
    step();
    wbc_cyc_i = 0; wbc_stb_i = 0; wbc_we_i = 0;
    step();
  endtask

  task automatic rd_reg(input int off);
    wb_access(reg_adr(off), 1'b0, 32'd0);
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    wb_access(reg_adr(0), 1'b1, d);
  endtask

  task automatic sample(input int chan, input logic [15:0] d);
    smp_valid_i = 1; smp_chan_i = 4'(chan); smp_dat_i = d;
    step();
    smp_valid_i = 0;
  endtask

  task automatic push_frame(input int f);
    for (int c = 0; c < NCHAN; c++) begin
      sample(c, 16'(f*16 + c));
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  // Monitor: pops one expectation per ack and checks the ack is one cycle wide.
  bit prev_ack = 0;
  always @(negedge clk) begin
    exp_t e;
    if (wbc_ack_o) begin
      vectors++;
      if (prev_ack) begin
        miscompares++;
        $display("FAIL ack_width: ack high %0d consecutive cycles, required 1", 2);
      end
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_ack: ack with no outstanding request");
      end else begin
        e = q.pop_front();
        if (e.chk) begin
          vectors++;
          if (wbc_dat_o !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", e.name, wbc_dat_o, e.exp);
          end
        end
      end
    end
    prev_ack = wbc_ack_o;
  end

  initial begin
    rst_i = 1; wbc_cyc_i = 0; wbc_stb_i = 0; wbc_we_i = 0; wbc_adr_i = '0;
    wbc_dat_i = '0; smp_valid_i = 0; smp_chan_i = '0; smp_dat_i = '0; pps_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 0;

    for (int r = 0; r < 4; r++) rd_reg(r);

    // Stop-on-full: four frames fill the buffer, a fifth sample overflows.
    wr_ctrl(32'h1);
    for (int f = 0; f < NF; f++) push_frame(f);
    rd_reg(1); rd_reg(2);
    wb_access(ram_adr(2, 5), 1'b0, 32'd0);
    sample(0, 16'h00AA);
    rd_reg(1);

    // Wrap mode: five frames, frame 0 overwritten by frame 4.
    wr_ctrl(32'h7);
    for (int f = 0; f < 5; f++) push_frame(f);
    rd_reg(1); rd_reg(2);
    for (int c = 0; c < NCHAN; c += 5) wb_access(ram_adr(0, c), 1'b0, 32'd0);

    sample(13, 16'hBEEF);
    rd_reg(1); rd_reg(2);
    wb_access(ram_adr(1, 13), 1'b0, 32'd0);

    // PPS tagging after three frames, held high to prove single capture.
    wr_ctrl(32'h7);
    for (int f = 0; f < 3; f++) push_frame(f);
    pps_i = 1;
    repeat (10) step();
    pps_i = 0;
    rd_reg(3);
    push_frame(3);
    rd_reg(3); rd_reg(2);

    // Clear in the same cycle as a frame-completing sample.
    wr_ctrl(32'h5);
    for (int c = 0; c < NCHAN-1; c++) sample(c, 16'(16'h0100 + c));
    smp_valid_i = 1; smp_chan_i = 4'(NCHAN-1); smp_dat_i = 16'h0DDD;
    wbc_cyc_i = 1; wbc_stb_i = 1; wbc_we_i = 1; wbc_adr_i = reg_adr(0); wbc_dat_i = 32'h5;
    step();
    smp_valid_i = 0; wbc_cyc_i = 0; wbc_stb_i = 0; wbc_we_i = 0;
    step();
    rd_reg(2); rd_reg(1); rd_reg(0);

    // Randomised phase: samples, PPS toggles, CTRL writes and reads interleaved.
    for (int i = 0; i < 600; i++) begin
      smp_valid_i = 1'($urandom_range(0, 1));
      smp_chan_i  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                               : 4'($urandom_range(0, 11));
      smp_dat_i   = 16'($urandom);
      if ($urandom_range(0, 15) == 0) pps_i = ~pps_i;
      if (m_ack == 0 && $urandom_range(0, 2) == 0) begin
        wbc_cyc_i = 1; wbc_stb_i = 1;
        case ($urandom_range(0, 9))
          0: begin
            wbc_we_i  = 1; wbc_adr_i = reg_adr(0);
            wbc_dat_i = {29'd0, ($urandom_range(0, 7) == 0), 1'($urandom),
                         ($urandom_range(0, 3) != 0)};
          end
          1, 2, 3: begin
            wbc_we_i = 0; wbc_adr_i = ram_adr($urandom_range(0, 3), $urandom_range(0, 11));
          end
          default: begin wbc_we_i = 0; wbc_adr_i = reg_adr($urandom_range(0, 3)); end
        endcase
      end else begin
        wbc_cyc_i = 0; wbc_stb_i = 0; wbc_we_i = 0;
      end
      step();
    end
    smp_valid_i = 0; wbc_cyc_i = 0; wbc_stb_i = 0; wbc_we_i = 0;
    for (int r = 0; r < 4; r++) rd_reg(r);
    repeat (4) step();

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL ack_timeout: %0d requests unacknowledged, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
